// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the system-ID slave.
interface kernel_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (output avm_address, avm_read, input avm_readdata);
    modport slave  (input avm_address, avm_read, output avm_readdata);
endinterface

// File: rtl/kernel_sysid_checker.sv
// Reads the system-ID word and the build-timestamp word, compares both with the expected image.
// Define SYSID_CHECKER_PERIODIC_EN to add a periodic re-check timer.
module kernel_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd2,
    parameter logic [31:0] EXPECTED_TS    = 32'd1504053489,
    parameter int unsigned READ_LATENCY   = 0,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned RECHECK_PERIOD = 50_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    kernel_sysid_checker_if.master        avm,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          match,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value,
    output logic                          fail_sticky
);
    // state   | meaning
    // IDLE    | waiting for start, auto-start or periodic trigger
    // RD_ID   | read strobe to word 0
    // WAIT_ID | counting slave latency for word 0
    // RD_TS   | read strobe to word 1
    // WAIT_TS | counting slave latency for word 1
    // DONE    | verdict published, done pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ID   = 3'd1;
    localparam logic [2:0] S_WAIT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS   = 3'd3;
    localparam logic [2:0] S_WAIT_TS = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0]  LAT_INIT  = 2'(READ_LATENCY);
    localparam logic [31:0] PERIOD_M1 = 32'(RECHECK_PERIOD - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] id_cap_q, id_cap_d;
    logic        pend_q, pend_d;
    logic        addr_q, addr_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        match_q, match_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        fail_q, fail_d;
    logic        ts_take;

`ifdef SYSID_CHECKER_PERIODIC_EN
    logic [31:0] per_q, per_d;
`else
    logic        unused_cfg;
    assign unused_cfg = ^PERIOD_M1;
`endif

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        id_cap_d   = id_cap_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        match_d    = match_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        fail_d     = fail_q;
        ts_take    = 1'b0;

`ifdef SYSID_CHECKER_PERIODIC_EN
        per_d = per_q;
        if (state_q == S_DONE || (state_q == S_IDLE && start)) begin
            per_d = PERIOD_M1;
        end else if (state_q == S_IDLE && per_q != 32'd0) begin
            per_d = per_q - 32'd1;
        end
        // timer expiry is turned into a pending request, serviced like an auto-start
        if (state_q == S_IDLE && per_q == 32'd0 && !start && !pend_q) begin
            pend_d = 1'b1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start || pend_q) begin
                    state_d = S_RD_ID;
                    pend_d  = 1'b0;
                    addr_d  = 1'b0;
                end
            end
            S_RD_ID: begin
                lat_d = LAT_INIT;
                if (READ_LATENCY == 0) begin
                    id_cap_d = avm.avm_readdata;
                    state_d  = S_RD_TS;
                    addr_d   = 1'b1;
                end else begin
                    state_d = S_WAIT_ID;
                end
            end
            S_WAIT_ID: begin
                if (lat_q == 2'd1) begin
                    id_cap_d = avm.avm_readdata;
                    state_d  = S_RD_TS;
                    addr_d   = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RD_TS: begin
                lat_d = LAT_INIT;
                if (READ_LATENCY == 0) begin
                    ts_take = 1'b1;
                end else begin
                    state_d = S_WAIT_TS;
                end
            end
            S_WAIT_TS: begin
                if (lat_q == 2'd1) begin
                    ts_take = 1'b1;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ts_take) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            id_value_d = id_cap_q;
            ts_value_d = avm.avm_readdata;
            id_ok_d    = (id_cap_q == EXPECTED_ID);
            ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
            match_d    = id_ok_d & ts_ok_d;
            fail_d     = fail_q | ~match_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_q      <= 2'd0;
            id_cap_q   <= 32'd0;
            pend_q     <= AUTO_START;
            addr_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            match_q    <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            id_cap_q   <= id_cap_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            match_q    <= match_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            fail_q     <= fail_d;
        end
    end

`ifdef SYSID_CHECKER_PERIODIC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per_q <= PERIOD_M1;
        end else begin
            per_q <= per_d;
        end
    end
`endif

    assign avm.avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm.avm_address = addr_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign match           = match_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
    assign fail_sticky     = fail_q;
endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: three instances (latency 0, latency 2, short recheck period).
module tb_kernel_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd2;
    localparam logic [31:0] EXP_TS = 32'd1504053489;
    localparam int LAT [3] = '{0, 2, 0};
    localparam int PER [3] = '{50_000_000, 50_000_000, 16};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]  start_w = 3'b000;
    logic [2:0]  busy_w, done_w, idok_w, tsok_w, match_w, fail_w, read_w, addr_w;
    logic [31:0] idv_w [3];
    logic [31:0] tsv_w [3];
    logic [31:0] slv_id = EXP_ID;
    logic [31:0] slv_ts = EXP_TS;

    for (genvar g = 0; g < 3; g++) begin : gi
        kernel_sysid_checker_if bus ();
        kernel_sysid_checker #(
            .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT[g]),
            .AUTO_START(1'b1), .RECHECK_PERIOD(PER[g])
        ) dut (
            .clock(clock), .reset(reset), .start(start_w[g]), .avm(bus.master),
            .busy(busy_w[g]), .done(done_w[g]), .id_ok(idok_w[g]), .ts_ok(tsok_w[g]),
            .match(match_w[g]), .id_value(idv_w[g]), .ts_value(tsv_w[g]),
            .fail_sticky(fail_w[g])
        );
        assign read_w[g] = bus.avm_read;
        assign addr_w[g] = bus.avm_address;

        // slave: word for a read issued in cycle c is presented during cycle c+LAT
        logic hv [4];
        logic ha [4];
        always @(negedge clock) begin
            for (int i = 3; i > 0; i--) begin
                hv[i] = hv[i-1];
                ha[i] = ha[i-1];
            end
            hv[0] = bus.avm_read;
            ha[0] = bus.avm_address;
            if (hv[LAT[g]] === 1'b1) bus.avm_readdata = (ha[LAT[g]] === 1'b1) ? slv_ts : slv_id;
            else                     bus.avm_readdata = $urandom;
        end
    end

    int cyc = 0;
    int dcnt [3] = '{0, 0, 0};
    int dcyc [3] = '{0, 0, 0};
    int pcyc [3] = '{0, 0, 0};
    int rcnt [3] = '{0, 0, 0};
    always @(posedge clock) begin
        #1;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            if (done_w[g] === 1'b1) begin
                pcyc[g] = dcyc[g];
                dcyc[g] = cyc;
                dcnt[g]++;
            end
            if (read_w[g] === 1'b1) rcnt[g]++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit sticky_m [3] = '{0, 0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_verdict(input int g, input string tag);
        bit eid, ets, em;
        eid = (slv_id == EXP_ID);
        ets = (slv_ts == EXP_TS);
        em  = eid && ets;
        if (!em) sticky_m[g] = 1'b1;
        chk({tag, ".id_ok"},    64'(idok_w[g]),  64'(eid));
        chk({tag, ".ts_ok"},    64'(tsok_w[g]),  64'(ets));
        chk({tag, ".match"},    64'(match_w[g]), 64'(em));
        chk({tag, ".id_value"}, 64'(idv_w[g]),   64'(slv_id));
        chk({tag, ".ts_value"}, 64'(tsv_w[g]),   64'(slv_ts));
        chk({tag, ".sticky"},   64'(fail_w[g]),  64'(sticky_m[g]));
    endtask

    task automatic await_done(input int g, input int x, input int d0, input int r0, input string tag);
        int n;
        n = 0;
        while (dcnt[g] == d0 && n < 80) begin
            @(negedge clock);
            n++;
        end
        chk({tag, ".timeout"}, 64'(dcnt[g] != d0), 64'd1);
        chk({tag, ".cycles"},  64'(dcyc[g] - x + 1), 64'(2 * (LAT[g] + 1) + 2));
        chk_verdict(g, tag);
        chk({tag, ".reads"},   64'(rcnt[g] - r0), 64'd2);
        @(negedge clock);
        chk({tag, ".one_pulse"}, 64'(dcnt[g] - d0), 64'd1);
        chk({tag, ".idle"},      64'(busy_w[g]), 64'd0);
    endtask

    task automatic do_check(input int g, input string tag);
        int x, d0, r0;
        @(negedge clock);
        x  = cyc;
        d0 = dcnt[g];
        r0 = rcnt[g];
        start_w[g] = 1'b1;
        @(negedge clock);
        start_w[g] = 1'b0;
        await_done(g, x, d0, r0, tag);
    endtask

    task automatic chk_reset_state(input int g, input string tag);
        chk({tag, ".busy"},  64'(busy_w[g]),  64'd0);
        chk({tag, ".done"},  64'(done_w[g]),  64'd0);
        chk({tag, ".match"}, 64'(match_w[g]), 64'd0);
        chk({tag, ".id_ok"}, 64'(idok_w[g]),  64'd0);
        chk({tag, ".idv"},   64'(idv_w[g]),   64'd0);
        chk({tag, ".tsv"},   64'(tsv_w[g]),   64'd0);
        chk({tag, ".fail"},  64'(fail_w[g]),  64'd0);
        chk({tag, ".read"},  64'(read_w[g]),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, n, g, d0c;
        int d0 [3];
        int r0 [3];

        // reset state and auto-start on all three instances
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) chk_reset_state(i, "reset");
        chk("reset.addr", 64'(addr_w[0]), 64'd0);
        x = cyc;
        for (int i = 0; i < 3; i++) begin
            d0[i] = dcnt[i];
            r0[i] = rcnt[i];
        end
        reset = 1'b0;
        await_done(0, x, d0[0], r0[0], "auto_a");
        await_done(1, x, d0[1], r0[1], "auto_b");
        await_done(2, x, d0[2], r0[2], "auto_c");

        // ID mismatch, then a passing re-check leaves fail_sticky set
        slv_id = 32'd3;
        do_check(0, "bad_id");
        slv_id = EXP_ID;
        do_check(0, "recheck");

        // randomized words, including single-bit corruptions of the timestamp
        for (int k = 0; k < 10; k++) begin
            g = $urandom_range(0, 1);
            slv_id = ($urandom_range(0, 2) != 0) ? EXP_ID : 32'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       slv_ts = EXP_TS;
                1:       slv_ts = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
                default: slv_ts = $urandom;
            endcase
            do_check(g, "rand");
        end

        // start pulses during RD_TS and DONE are dropped
        slv_id = EXP_ID;
        slv_ts = EXP_TS;
        @(negedge clock);
        d0[0] = dcnt[0];
        start_w[0] = 1'b1;
        @(negedge clock);
        start_w[0] = 1'b0;
        n = 0;
        while (!(read_w[0] === 1'b1 && addr_w[0] === 1'b1) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ign.in_rd_ts", 64'(read_w[0] & addr_w[0]), 64'd1);
        start_w[0] = 1'b1;
        @(negedge clock);
        start_w[0] = 1'b0;
        chk("ign.in_done", 64'(done_w[0]), 64'd1);
        start_w[0] = 1'b1;
        @(negedge clock);
        start_w[0] = 1'b0;
        repeat (10) @(negedge clock);
        chk("ign.one_done", 64'(dcnt[0] - d0[0]), 64'd1);
        chk("ign.idle", 64'(busy_w[0]), 64'd0);
        do_check(0, "after_ign");

        // reset in WAIT_ID of the latency-2 instance
        @(negedge clock);
        start_w[1] = 1'b1;
        @(negedge clock);
        start_w[1] = 1'b0;
        chk("rst.rd_id", 64'({read_w[1], addr_w[1]}), 64'd2);
        @(negedge clock);
        chk("rst.wait_id", 64'({busy_w[1], read_w[1]}), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk_reset_state(1, "rst_mid");
        for (int i = 0; i < 3; i++) sticky_m[i] = 1'b0;
        repeat (2) @(negedge clock);
        x = cyc;
        d0[1] = dcnt[1];
        r0[1] = rcnt[1];
        d0c = dcnt[2];
        reset = 1'b0;
        await_done(1, x, d0[1], r0[1], "rst_auto");

        // periodic re-check on the short-period instance
`ifdef SYSID_CHECKER_PERIODIC_EN
        n = 0;
        while (dcnt[2] < d0c + 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("per.timeout", 64'(dcnt[2] >= d0c + 3), 64'd1);
        chk("per.interval", 64'(dcyc[2] - pcyc[2]), 64'(PER[2] + 2 * (LAT[2] + 1) + 2));
        chk("per.match", 64'(match_w[2]), 64'd1);
`else
        repeat (80) @(negedge clock);
        chk("per.single_done", 64'(dcnt[2] - d0c), 64'd1);
        chk("per.idle", 64'(busy_w[2]), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
